// File: rtl/nbr_table_writer_if.sv
`default_nettype none
// ============================================================================
// nbr_table_writer_if: update handshake plus word-memory port bundle
// Revision 1.0
// ============================================================================
interface nbr_table_writer_if;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] nbr_id;
  logic [15:0] nbr_q;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        done;
  logic        hit;
  logic        overflow;

  modport slave (
    input  en, in_valid, nbr_id, nbr_q, data_in,
    output in_ready, address, wr_en, data_out, done, hit, overflow
  );

  modport master (
    output en, in_valid, nbr_id, nbr_q, data_in,
    input  in_ready, address, wr_en, data_out, done, hit, overflow
  );
endinterface
`default_nettype wire

// File: rtl/nbr_table_writer.sv
`default_nettype none
// ============================================================================
// nbr_table_writer: inserts or refreshes one (id, q) pair in a memory-resident neighbor table
// Revision 1.0
// ============================================================================
module nbr_table_writer #(
  parameter int unsigned MAX_NBR  = 16,
  parameter logic [10:0] CNT_ADDR = 11'h274,
  parameter logic [10:0] ID_BASE  = 11'h0A0,
  parameter logic [10:0] Q_BASE   = 11'h132
) (
  input logic               clock,
  input logic               nrst,
  nbr_table_writer_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_NBR + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RDCNT, S_CMP, S_WRID, S_WRQ, S_WRCNT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   address_q, address_d;
  logic [15:0]   data_out_q, data_out_d;
  logic [15:0]   id_q, id_d;
  logic [15:0]   qv_q, qv_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic          overflow_q, overflow_d;
  logic          match_q, match_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] tgt_q, tgt_d;

  logic          ready;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] idx_inc;
  logic [CW-1:0] dec_count;
  logic          do_append;

  assign ready    = (state_q == S_IDLE) && bus.en;
  // A corrupted stored count larger than the table is treated as a full table.
  assign rd_count = (bus.data_in > 16'(MAX_NBR)) ? CW'(MAX_NBR) : CW'(bus.data_in);
  assign idx_inc  = idx_q + CW'(1);

  assign bus.in_ready = ready;
  assign bus.address  = address_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.hit      = hit_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      address_q  <= CNT_ADDR;
      data_out_q <= '0;
      id_q       <= '0;
      qv_q       <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      id_q       <= id_d;
      qv_q       <= qv_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      overflow_q <= overflow_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    id_d       = id_q;
    qv_d       = qv_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    hit_d      = 1'b0;
    overflow_d = 1'b0;
    match_d    = match_q;
    idx_d      = idx_q;
    count_d    = count_q;
    tgt_d      = tgt_q;
    do_append  = 1'b0;
    dec_count  = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && ready) begin
          id_d      = bus.nbr_id;
          qv_d      = bus.nbr_q;
          match_d   = 1'b0;
          address_d = CNT_ADDR;
          state_d   = S_RDCNT;
        end
      end
      S_RDCNT: begin
        count_d   = rd_count;
        idx_d     = '0;
        dec_count = rd_count;
        if (rd_count == '0) begin
          do_append = 1'b1;
        end else begin
          address_d = ID_BASE;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        if (bus.data_in == id_q) begin
          match_d    = 1'b1;
          tgt_d      = idx_q;
          wr_en_d    = 1'b1;
          address_d  = Q_BASE + 11'(idx_q);
          data_out_d = qv_q;
          state_d    = S_WRQ;
        end else if (idx_inc == count_q) begin
          do_append = 1'b1;
        end else begin
          idx_d     = idx_inc;
          address_d = ID_BASE + 11'(idx_inc);
        end
      end
      S_WRID: begin
        wr_en_d    = 1'b1;
        address_d  = Q_BASE + 11'(tgt_q);
        data_out_d = qv_q;
        state_d    = S_WRQ;
      end
      S_WRQ: begin
        if (match_q) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en_d    = 1'b1;
          address_d  = CNT_ADDR;
          data_out_d = 16'(count_q) + 16'd1;
          state_d    = S_WRCNT;
        end
      end
      S_WRCNT: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared by the empty-table exit of S_RDCNT and the no-match exit of S_CMP.
    if (do_append) begin
      if (dec_count == CW'(MAX_NBR)) begin
        done_d     = 1'b1;
        overflow_d = 1'b1;
        state_d    = S_DONE;
      end else begin
        tgt_d      = dec_count;
        wr_en_d    = 1'b1;
        address_d  = ID_BASE + 11'(dec_count);
        data_out_d = id_q;
        state_d    = S_WRID;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_nbr_table_writer.sv
`default_nettype none
// ============================================================================
// tb_nbr_table_writer: random and directed updates checked against a table-level model
// Revision 1.0
// ============================================================================
module tb_nbr_table_writer;
  localparam int          MAX = 16;
  localparam logic [10:0] CNT = 11'h274;
  localparam logic [10:0] IDB = 11'h0A0;
  localparam logic [10:0] QB  = 11'h132;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  nbr_table_writer_if bus();

  nbr_table_writer #(.MAX_NBR(MAX), .CNT_ADDR(CNT), .ID_BASE(IDB), .Q_BASE(QB)) dut (
    .clock(clock),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem       [0:2047];
  logic [15:0] model_mem [0:2047];
  logic        tb_we   = 1'b0;
  logic [10:0] tb_addr = '0;
  logic [15:0] tb_data = '0;
  int          wr_pulses = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Memory answers combinationally from the registered address, so data is ready by the next edge.
  assign bus.data_in = mem[bus.address];

  always @(posedge clock) begin
    if (bus.wr_en) begin
      mem[bus.address] <= bus.data_out;
      wr_pulses        <= wr_pulses + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = a; tb_data = d; model_mem[a] = d;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  task automatic load_table(input logic [15:0] cnt_word, input bit rand_ids, input logic [15:0] base);
    poke(CNT, cnt_word);
    for (int i = 0; i < MAX; i++) begin
      poke(IDB + 11'(i), rand_ids ? 16'($urandom_range(31, 0)) : base + 16'(i));
      poke(QB + 11'(i), 16'($urandom));
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    if (mem[CNT] !== model_mem[CNT]) d++;
    for (int i = 0; i < MAX; i++) begin
      if (mem[IDB + 11'(i)] !== model_mem[IDB + 11'(i)]) d++;
      if (mem[QB + 11'(i)] !== model_mem[QB + 11'(i)]) d++;
    end
    return d;
  endfunction

  // Table-level rules: first match refreshes q; otherwise append unless full.
  task automatic model_update(input logic [15:0] id, input logic [15:0] q,
                              output bit h, output bit o, output int nw,
                              output int lat, output bit lat_chk);
    int cnt;
    int found;
    cnt   = (model_mem[CNT] > 16'(MAX)) ? MAX : int'(model_mem[CNT]);
    found = -1;
    for (int i = 0; i < cnt; i++)
      if (found < 0 && model_mem[IDB + 11'(i)] == id) found = i;
    h = 0; o = 0; nw = 0; lat = 0; lat_chk = 0;
    if (found >= 0) begin
      h = 1; nw = 1; lat = 4 + found; lat_chk = 1;
      model_mem[QB + 11'(found)] = q;
    end else if (cnt == MAX) begin
      o = 1;
    end else begin
      nw = 3; lat = 5 + cnt; lat_chk = (cnt > 0);
      model_mem[IDB + 11'(cnt)] = id;
      model_mem[QB + 11'(cnt)]  = q;
      model_mem[CNT]            = 16'(cnt + 1);
    end
  endtask

  task automatic apply(input logic [15:0] id, input logic [15:0] q, input bit drop_en,
                       output bit o_hit, output bit o_ovf, output int o_lat, output int o_wr,
                       output bit o_busy_rdy, output bit o_to);
    int w0;
    int n;
    o_hit = 0; o_ovf = 0; o_lat = 0; o_wr = 0; o_busy_rdy = 0; o_to = 0;
    @(negedge clock);
    bus.en = 1'b1; bus.nbr_id = id; bus.nbr_q = q; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clock); n++; end
    if (!bus.in_ready) begin o_to = 1; bus.in_valid = 1'b0; return; end
    w0 = wr_pulses;
    @(posedge clock);
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.done || n >= 100) break;
      if (bus.in_ready) o_busy_rdy = 1;
      bus.in_valid = 1'($urandom_range(1, 0));
      bus.nbr_id   = 16'($urandom);
      bus.nbr_q    = 16'($urandom);
      if (drop_en) bus.en = 1'b0;
      @(posedge clock);
      n++;
    end
    bus.in_valid = 1'b0;
    bus.en       = 1'b1;
    if (!bus.done) begin o_to = 1; return; end
    o_hit = bus.hit; o_ovf = bus.overflow; o_lat = n + 1;
    if (bus.in_ready) o_busy_rdy = 1;
    @(negedge clock);
    o_wr = wr_pulses - w0;
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.in_valid = 1'b0; bus.nbr_id = '0; bus.nbr_q = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (bus.address !== CNT) begin n_err++; $display("FAIL reset_address: got %h want %h", bus.address, CNT); end
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.data_out !== 16'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
    n_vec++; if ({bus.done, bus.hit, bus.overflow} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.done, bus.hit, bus.overflow}); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    nrst = 1'b1;
  endtask

  task automatic test_empty_append();
    bit h, o, lc, eh, eo, br, to; int lat, w, ew, el;
    load_table(16'd0, 0, 16'h0300);
    model_update(16'h0005, 16'h1200, eh, eo, ew, el, lc);
    apply(16'h0005, 16'h1200, 0, h, o, lat, w, br, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL empty_timeout: got %b want 0", to); end
    n_vec++; if ({h, o} !== 2'b00) begin n_err++; $display("FAIL empty_hit_ovf: got %b want 00", {h, o}); end
    n_vec++; if (w !== 3) begin n_err++; $display("FAIL empty_writes: got %0d want 3", w); end
    n_vec++; if ({mem[11'h0A0], mem[11'h132], mem[11'h274]} !== {16'h0005, 16'h1200, 16'h0001})
      begin n_err++; $display("FAIL empty_mem: got %h %h %h want 0005 1200 0001", mem[11'h0A0], mem[11'h132], mem[11'h274]); end
    n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL empty_table: got %0d differing words want 0", mem_diffs()); end
  endtask

  task automatic test_hit_update();
    bit h, o, lc, eh, eo, br, to; int lat, w, ew, el;
    load_table(16'd3, 0, 16'h0400);
    poke(IDB, 16'd7); poke(IDB + 11'd1, 16'd9); poke(IDB + 11'd2, 16'd5);
    model_update(16'd9, 16'h0800, eh, eo, ew, el, lc);
    apply(16'd9, 16'h0800, 1, h, o, lat, w, br, to);
    n_vec++; if ({to, h, o} !== 3'b010) begin n_err++; $display("FAIL hit_flags: got to/hit/ovf=%b want 010", {to, h, o}); end
    n_vec++; if (w !== 1) begin n_err++; $display("FAIL hit_writes: got %0d want 1", w); end
    n_vec++; if ({mem[11'h133], mem[CNT]} !== {16'h0800, 16'h0003}) begin n_err++; $display("FAIL hit_mem: got %h %h want 0800 0003", mem[11'h133], mem[CNT]); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL hit_latency: got %0d want 5", lat); end
    n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL hit_table: got %0d differing words want 0", mem_diffs()); end
  endtask

  task automatic test_first_match();
    bit h, o, lc, eh, eo, br, to; int lat, w, ew, el;
    logic [15:0] q_dup;
    load_table(16'd3, 0, 16'h0500);
    poke(IDB, 16'd3); poke(IDB + 11'd1, 16'd8); poke(IDB + 11'd2, 16'd3);
    q_dup = mem[QB + 11'd2];
    model_update(16'd3, 16'hBEEF, eh, eo, ew, el, lc);
    apply(16'd3, 16'hBEEF, 0, h, o, lat, w, br, to);
    n_vec++; if ({to, h, mem[QB]} !== {1'b0, 1'b1, 16'hBEEF}) begin n_err++; $display("FAIL first_match: got to=%b hit=%b q0=%h want 0 1 beef", to, h, mem[QB]); end
    n_vec++; if (mem[QB + 11'd2] !== q_dup) begin n_err++; $display("FAIL dup_untouched: got %h want %h", mem[QB + 11'd2], q_dup); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL first_latency: got %0d want 4", lat); end
  endtask

  task automatic test_overflow(input logic [15:0] cnt_word, input logic [15:0] id);
    bit h, o, lc, eh, eo, br, to; int lat, w, ew, el;
    load_table(cnt_word, 0, 16'h0100);
    model_update(id, 16'h1234, eh, eo, ew, el, lc);
    apply(id, 16'h1234, 0, h, o, lat, w, br, to);
    n_vec++; if ({to, h, o} !== 3'b001) begin n_err++; $display("FAIL ovf_flags_%h: got to/hit/ovf=%b want 001", cnt_word, {to, h, o}); end
    n_vec++; if (w !== 0) begin n_err++; $display("FAIL ovf_writes_%h: got %0d want 0", cnt_word, w); end
    n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL ovf_table_%h: got %0d differing words want 0", cnt_word, mem_diffs()); end
  endtask

  task automatic test_en_gating();
    bit rdy, dn; int w0;
    load_table(16'd0, 0, 16'h0600);
    @(negedge clock);
    bus.en = 1'b0; bus.in_valid = 1'b1; bus.nbr_id = 16'h0042; bus.nbr_q = 16'h0042;
    w0 = wr_pulses; rdy = 0; dn = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.in_ready) rdy = 1;
      if (bus.done) dn = 1;
    end
    bus.in_valid = 1'b0; bus.en = 1'b1;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL en_gate_ready: got %b want 0", rdy); end
    n_vec++; if ({dn, wr_pulses - w0} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL en_gate_activity: got done=%b writes=%0d want 0 0", dn, wr_pulses - w0); end
  endtask

  task automatic test_back_to_back();
    bit h, o, lc, busy_rdy, got_done; int nw, el, w0, n;
    logic [15:0] qa, qb;
    load_table(16'd0, 0, 16'h0700);
    qa = 16'($urandom); qb = 16'($urandom);
    model_update(16'h0E01, qa, h, o, nw, el, lc);
    model_update(16'h0E02, qb, h, o, nw, el, lc);
    @(negedge clock);
    bus.en = 1'b1; bus.in_valid = 1'b1; bus.nbr_id = 16'h0E01; bus.nbr_q = qa;
    w0 = wr_pulses;
    @(posedge clock);
    @(negedge clock);
    bus.nbr_id = 16'h0E02; bus.nbr_q = qb;
    busy_rdy = 0; n = 0;
    while (!bus.done && n < 100) begin
      if (bus.in_ready) busy_rdy = 1;
      @(negedge clock); n++;
    end
    got_done = bus.done;
    n_vec++; if ({got_done, busy_rdy, bus.in_ready} !== 3'b100) begin n_err++; $display("FAIL b2b_first: got done/busy_ready/ready=%b want 100", {got_done, busy_rdy, bus.in_ready}); end
    @(negedge clock);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept: got %b want 1", bus.in_ready); end
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clock); n++; end
    got_done = bus.done;
    @(negedge clock);
    n_vec++; if ({got_done, wr_pulses - w0} !== {1'b1, 32'd6}) begin n_err++; $display("FAIL b2b_second: got done=%b writes=%0d want 1 6", got_done, wr_pulses - w0); end
    n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL b2b_table: got %0d differing words want 0", mem_diffs()); end
  endtask

  task automatic test_reset_in_wrid();
    bit dn; int w0, n;
    load_table(16'd2, 0, 16'h0800);
    @(negedge clock);
    bus.en = 1'b1; bus.in_valid = 1'b1; bus.nbr_id = 16'h0777; bus.nbr_q = 16'h9999;
    w0 = wr_pulses;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    n = 0;
    while (!(bus.wr_en && bus.address == IDB + 11'd2) && n < 50) begin @(negedge clock); n++; end
    n_vec++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL rst_wrid_reach: got wr_en=%b want 1", bus.wr_en); end
    nrst = 1'b0;
    model_mem[IDB + 11'd2] = 16'h0777;
    @(posedge clock);
    @(negedge clock);
    n_vec++; if ({bus.wr_en, bus.done, bus.hit, bus.overflow} !== 4'b0000) begin n_err++; $display("FAIL rst_wrid_flags: got %b want 0000", {bus.wr_en, bus.done, bus.hit, bus.overflow}); end
    n_vec++; if ({bus.address, bus.data_out} !== {CNT, 16'h0}) begin n_err++; $display("FAIL rst_wrid_bus: got %h %h want %h 0000", bus.address, bus.data_out, CNT); end
    @(negedge clock);
    nrst = 1'b1;
    dn = 0;
    repeat (8) begin @(negedge clock); if (bus.done) dn = 1; end
    n_vec++; if ({dn, wr_pulses - w0} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL rst_wrid_writes: got done=%b writes=%0d want 0 1", dn, wr_pulses - w0); end
    n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL rst_wrid_table: got %0d differing words want 0", mem_diffs()); end
  endtask

  task automatic test_random();
    bit h, o, lc, eh, eo, br, to, drop; int lat, w, ew, el, r;
    logic [15:0] id, q, cw;
    for (int k = 0; k < 64; k++) begin
      if (k % 16 == 0) begin
        r  = $urandom_range(5, 0);
        cw = (r == 0) ? 16'd0 : (r == 1) ? 16'(MAX) : (r == 2) ? 16'h0030 : 16'($urandom_range(MAX - 1, 1));
        load_table(cw, 1, 16'h0);
      end
      id   = 16'($urandom_range(31, 0));
      q    = 16'($urandom);
      drop = ($urandom_range(3, 0) == 0);
      model_update(id, q, eh, eo, ew, el, lc);
      apply(id, q, drop, h, o, lat, w, br, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout: got %b want 0", k, to); end
      n_vec++; if ({h, o} !== {eh, eo}) begin n_err++; $display("FAIL rnd%0d_hit_ovf: got %b%b want %b%b (id %h)", k, h, o, eh, eo, id); end
      n_vec++; if (w !== ew) begin n_err++; $display("FAIL rnd%0d_writes: got %0d want %0d", k, w, ew); end
      n_vec++; if (br !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy_ready: got %b want 0", k, br); end
      n_vec++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL rnd%0d_table: got %0d differing words want 0", k, mem_diffs()); end
      if (lc) begin
        n_vec++; if (lat !== el) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, el); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_append();
    test_hit_update();
    test_first_match();
    test_overflow(16'd16, 16'h00AA);
    test_overflow(16'h0030, 16'h0055);
    test_en_gating();
    test_back_to_back();
    test_reset_in_wrid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
